// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared byte format and encodings for the eth_tx_sel slice
package eth_pkg;

    localparam int ETH_BYTE_W  = 10;
    localparam int ETH_SOP_BIT = 9;
    localparam int ETH_EOP_BIT = 8;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_RR     = 2'd1,
        MODE_PRIO   = 2'd2,
        MODE_RR_ALT = 2'd3
    } eth_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } eth_tx_state_e;

endpackage

// File: rtl/eth_pkt_fifo.sv
// rtl/eth_pkt_fifo.sv - per-channel store-and-forward packet FIFO
// Write pointer rewinds to the open packet start on overflow or a restarting SOP.
module eth_pkt_fifo
    import eth_pkg::*;
#(
    parameter int pDepth = 2048
) (
    input  logic                  Clk,
    input  logic                  Rstn,
    input  logic                  i_wr_valid,
    input  logic [ETH_BYTE_W-1:0] i_wr_byte,
    input  logic                  i_rd_en,
    output logic [ETH_BYTE_W-1:0] o_rd_byte,
    output logic                  o_pkt_avail,
    output logic                  o_drop
);

    localparam int AW = $clog2(pDepth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(pDepth);

    logic [ETH_BYTE_W-1:0] r_mem [pDepth];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_pkt_start;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_pkt_cnt;
    logic                  r_open;
    logic                  r_stray;
    logic                  r_drop;

    logic          w_sop;
    logic          w_eop;
    logic [PW-1:0] w_addr;
    logic          w_full;
    logic          w_we;
    logic          w_commit;
    logic          w_rd_eop;
    logic [PW-1:0] w_wr_ptr_n;
    logic [PW-1:0] w_start_n;
    logic          w_open_n;
    logic          w_stray_n;
    logic          w_drop_n;

    assign w_sop    = i_wr_byte[ETH_SOP_BIT];
    assign w_eop    = i_wr_byte[ETH_EOP_BIT];
    // With no packet open r_pkt_start equals r_wr_ptr, so a SOP always lands at the start.
    assign w_addr   = w_sop ? r_pkt_start : r_wr_ptr;
    assign w_full   = (w_addr - r_rd_ptr) == DEPTH_P;
    assign o_rd_byte   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_rd_eop    = i_rd_en & o_rd_byte[ETH_EOP_BIT];
    assign o_pkt_avail = (r_pkt_cnt != '0);
    assign o_drop      = r_drop;

    always_comb begin
        w_we       = 1'b0;
        w_commit   = 1'b0;
        w_wr_ptr_n = r_wr_ptr;
        w_start_n  = r_pkt_start;
        w_open_n   = r_open;
        w_stray_n  = r_stray;
        w_drop_n   = 1'b0;
        if (i_wr_valid) begin
            if (w_sop) begin
                w_stray_n = 1'b0;
                w_drop_n  = r_open;
                if (w_full) begin
                    w_drop_n   = 1'b1;
                    w_wr_ptr_n = r_pkt_start;
                    w_open_n   = 1'b0;
                    w_stray_n  = 1'b1;
                end else begin
                    w_we       = 1'b1;
                    w_wr_ptr_n = r_pkt_start + 1'b1;
                    if (w_eop) begin
                        w_start_n = r_pkt_start + 1'b1;
                        w_open_n  = 1'b0;
                        w_commit  = 1'b1;
                    end else begin
                        w_open_n  = 1'b1;
                    end
                end
            end else if (r_open) begin
                if (w_full) begin
                    w_drop_n   = 1'b1;
                    w_wr_ptr_n = r_pkt_start;
                    w_open_n   = 1'b0;
                    w_stray_n  = 1'b1;
                end else begin
                    w_we       = 1'b1;
                    w_wr_ptr_n = r_wr_ptr + 1'b1;
                    if (w_eop) begin
                        w_start_n = r_wr_ptr + 1'b1;
                        w_open_n  = 1'b0;
                        w_commit  = 1'b1;
                    end
                end
            end else if (!r_stray) begin
                w_drop_n  = 1'b1;
                w_stray_n = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_we) begin
            r_mem[w_addr[AW-1:0]] <= i_wr_byte;
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            r_wr_ptr    <= '0;
            r_pkt_start <= '0;
            r_rd_ptr    <= '0;
            r_pkt_cnt   <= '0;
            r_open      <= 1'b0;
            r_stray     <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_n;
            r_pkt_start <= w_start_n;
            r_open      <= w_open_n;
            r_stray     <= w_stray_n;
            r_drop      <= w_drop_n;
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_commit && !w_rd_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (!w_commit && w_rd_eop) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_sel.sv
// rtl/eth_tx_sel.sv - multi-channel packet selector feeding eth_tx
// The first byte is read in the grant cycle so it appears one cycle after the grant.
module eth_tx_sel
    import eth_pkg::*;
#(
    parameter int pNum_Ch     = 4,
    parameter int pFifo_Depth = 2048
) (
    input  logic                          Clk,
    input  logic                          Rstn,
    input  logic [pNum_Ch*ETH_BYTE_W-1:0] Ch_Byte,
    input  logic [pNum_Ch-1:0]            Ch_Byte_Valid,
    input  logic [1:0]                    Mode,
    input  logic [$clog2(pNum_Ch)-1:0]    Fixed_Ch,
    output logic [ETH_BYTE_W-1:0]         Eth_Byte,
    output logic                          Eth_Byte_Valid,
    output logic [pNum_Ch-1:0]            Ch_Drop,
    output logic                          Busy
);

    localparam int CW = $clog2(pNum_Ch);

    eth_tx_state_e         r_state;
    eth_tx_state_e         w_state_n;
    logic [ETH_BYTE_W-1:0] r_eth_byte;
    logic                  r_eth_valid;
    logic [CW-1:0]         r_gnt_ch;
    logic [CW-1:0]         r_rr_next;

    logic [ETH_BYTE_W-1:0] w_rd_byte [pNum_Ch];
    logic [pNum_Ch-1:0]    w_avail;
    logic [pNum_Ch-1:0]    w_rd_en;
    logic                  w_gnt_vld;
    logic [CW-1:0]         w_gnt_ch;
    logic [CW-1:0]         w_idx;
    logic [CW-1:0]         w_sel;

    for (genvar g = 0; g < pNum_Ch; g++) begin : g_ch
        eth_pkt_fifo #(
            .pDepth (pFifo_Depth)
        ) u_fifo (
            .Clk         (Clk),
            .Rstn        (Rstn),
            .i_wr_valid  (Ch_Byte_Valid[g]),
            .i_wr_byte   (Ch_Byte[g*ETH_BYTE_W +: ETH_BYTE_W]),
            .i_rd_en     (w_rd_en[g]),
            .o_rd_byte   (w_rd_byte[g]),
            .o_pkt_avail (w_avail[g]),
            .o_drop      (Ch_Drop[g])
        );
    end

    // Loops run from the far end so the last hit is the winner.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = '0;
        case (Mode)
            MODE_FIXED: begin
                if (int'(Fixed_Ch) < pNum_Ch && w_avail[Fixed_Ch]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_ch  = Fixed_Ch;
                end
            end
            MODE_PRIO: begin
                for (int i = pNum_Ch - 1; i >= 0; i--) begin
                    if (w_avail[CW'(i)]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_ch  = CW'(i);
                    end
                end
            end
            default: begin
                for (int i = pNum_Ch - 1; i >= 0; i--) begin
                    w_idx = CW'((int'(r_rr_next) + i) % pNum_Ch);
                    if (w_avail[w_idx]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_ch  = w_idx;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_rd_en   = '0;
        w_sel     = r_gnt_ch;
        case (r_state)
            ST_IDLE: begin
                w_sel = w_gnt_ch;
                if (w_gnt_vld) begin
                    w_rd_en[w_gnt_ch] = 1'b1;
                    w_state_n         = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_eth_byte[ETH_EOP_BIT]) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_rd_en[r_gnt_ch] = 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            r_eth_byte  <= '0;
            r_eth_valid <= 1'b0;
            r_gnt_ch    <= '0;
            r_rr_next   <= '0;
        end else begin
            if (|w_rd_en) begin
                r_eth_byte  <= w_rd_byte[w_sel];
                r_eth_valid <= 1'b1;
            end else begin
                r_eth_byte  <= '0;
                r_eth_valid <= 1'b0;
            end
            if (r_state == ST_IDLE && w_gnt_vld) begin
                r_gnt_ch  <= w_gnt_ch;
                r_rr_next <= CW'((int'(w_gnt_ch) + 1) % pNum_Ch);
            end
        end
    end

    assign Eth_Byte       = r_eth_byte;
    assign Eth_Byte_Valid = r_eth_valid;
    assign Busy           = (r_state == ST_SEND);

endmodule

// File: tb/tb_eth_tx_sel.sv
// tb/tb_eth_tx_sel.sv - directed self-checking bench for eth_tx_sel
module tb_eth_tx_sel;
    import eth_pkg::*;

    localparam int NCH   = 4;
    localparam int DEPTH = 16;

    logic              Clk = 1'b0;
    logic              Rstn;
    logic [NCH*10-1:0] Ch_Byte;
    logic [NCH-1:0]    Ch_Byte_Valid;
    logic [1:0]        Mode;
    logic [1:0]        Fixed_Ch;
    logic [9:0]        Eth_Byte;
    logic              Eth_Byte_Valid;
    logic [NCH-1:0]    Ch_Drop;
    logic              Busy;

    eth_tx_sel #(
        .pNum_Ch     (NCH),
        .pFifo_Depth (DEPTH)
    ) dut (
        .Clk            (Clk),
        .Rstn           (Rstn),
        .Ch_Byte        (Ch_Byte),
        .Ch_Byte_Valid  (Ch_Byte_Valid),
        .Mode           (Mode),
        .Fixed_Ch       (Fixed_Ch),
        .Eth_Byte       (Eth_Byte),
        .Eth_Byte_Valid (Eth_Byte_Valid),
        .Ch_Drop        (Ch_Drop),
        .Busy           (Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    logic [9:0] oq[$];
    int         cq[$];
    int         drop_cnt [NCH] = '{default: 0};
    int         zero_viol = 0;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Eth_Byte_Valid) begin
            oq.push_back(Eth_Byte);
            cq.push_back(cyc);
        end else if (Eth_Byte != 10'd0) begin
            zero_viol++;
        end
        for (int c = 0; c < NCH; c++) begin
            if (Ch_Drop[c]) drop_cnt[c]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic s, input logic e, input int d);
        return {s, e, 8'(d)};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [9:0] b);
        Ch_Byte[ch*10 +: 10] = b;
        Ch_Byte_Valid[ch]    = 1'b1;
        step();
        Ch_Byte       = '0;
        Ch_Byte_Valid = '0;
    endtask

    task automatic put_pkt(input int ch, input int n, input int base);
        for (int i = 0; i < n; i++) put(ch, mk(i == 0, i == n - 1, base + i));
    endtask

    task automatic put2_pkt(input int c0, input int c1, input int n, input int b0, input int b1);
        for (int i = 0; i < n; i++) begin
            Ch_Byte[c0*10 +: 10] = mk(i == 0, i == n - 1, b0 + i);
            Ch_Byte[c1*10 +: 10] = mk(i == 0, i == n - 1, b1 + i);
            Ch_Byte_Valid[c0]    = 1'b1;
            Ch_Byte_Valid[c1]    = 1'b1;
            step();
        end
        Ch_Byte       = '0;
        Ch_Byte_Valid = '0;
    endtask

    task automatic expect_pkt(input string tag, input int at, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            if (at + i < oq.size()) check(tag, 32'(oq[at+i]), 32'(mk(i == 0, i == n - 1, base + i)));
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!Eth_Byte_Valid && k < 60) begin
            step();
            k++;
        end
        check(tag, 32'(k < 60), 32'd1);
    endtask

    initial begin
        int b;
        int d;
        int n;
        int eops;
        Rstn          = 1'b0;
        Ch_Byte       = '0;
        Ch_Byte_Valid = '0;
        Mode          = 2'd1;
        Fixed_Ch      = 2'd0;
        repeat (3) step();
        check("rst_valid", 32'(Eth_Byte_Valid), 32'd0);
        check("rst_byte", 32'(Eth_Byte), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_drop", 32'(Ch_Drop), 32'd0);
        Rstn = 1'b1;
        step();

        // round-robin, simultaneous packets on ch0 and ch2
        b = oq.size();
        put2_pkt(0, 2, 3, 8'h10, 8'h20);
        repeat (12) step();
        check("rr_count", 32'(oq.size() - b), 32'd6);
        expect_pkt("rr_ch0", b, 3, 8'h10);
        expect_pkt("rr_ch2", b + 3, 3, 8'h20);
        if (oq.size() >= b + 6) begin
            check("rr_gap01", 32'(cq[b+1] - cq[b]), 32'd1);
            check("rr_gap12", 32'(cq[b+2] - cq[b+1]), 32'd1);
            check("rr_idle", 32'(cq[b+3] - cq[b+2]), 32'd2);
        end

        // strict priority: ch3 then ch1 loaded while held in fixed mode on empty ch0
        Mode = 2'd0;
        Fixed_Ch = 2'd0;
        b = oq.size();
        put_pkt(3, 2, 8'h30);
        put_pkt(1, 3, 8'h40);
        repeat (5) step();
        check("fix_hold", 32'(oq.size() - b), 32'd0);
        Mode = 2'd2;
        repeat (14) step();
        check("prio_count", 32'(oq.size() - b), 32'd5);
        expect_pkt("prio_ch1", b, 3, 8'h40);
        expect_pkt("prio_ch3", b + 3, 2, 8'h30);

        // overflow on ch1 with a 16-entry FIFO
        Mode = 2'd1;
        d = drop_cnt[1];
        b = oq.size();
        put_pkt(1, 20, 8'h60);
        repeat (6) step();
        check("ovf_drop", 32'(drop_cnt[1] - d), 32'd1);
        check("ovf_noout", 32'(oq.size() - b), 32'd0);
        put_pkt(1, 4, 8'h90);
        repeat (10) step();
        check("ovf_next_count", 32'(oq.size() - b), 32'd4);
        expect_pkt("ovf_next", b, 4, 8'h90);
        check("ovf_drop_once", 32'(drop_cnt[1] - d), 32'd1);

        // SOP-only byte followed by a full packet on ch0
        d = drop_cnt[0];
        b = oq.size();
        put(0, mk(1'b1, 1'b0, 8'h50));
        put_pkt(0, 3, 8'h51);
        repeat (8) step();
        check("resop_drop", 32'(drop_cnt[0] - d), 32'd1);
        check("resop_count", 32'(oq.size() - b), 32'd3);
        expect_pkt("resop_pkt", b, 3, 8'h51);

        // stray run on ch3 then a one-byte packet
        d = drop_cnt[3];
        put(3, mk(1'b0, 1'b0, 8'h71));
        put(3, mk(1'b0, 1'b1, 8'h72));
        step();
        check("stray_drop", 32'(drop_cnt[3] - d), 32'd1);
        b = oq.size();
        put(3, mk(1'b1, 1'b1, 8'h7A));
        repeat (5) step();
        check("one_count", 32'(oq.size() - b), 32'd1);
        if (oq.size() > b) check("one_byte", 32'(oq[b]), 32'(mk(1'b1, 1'b1, 8'h7A)));
        check("one_nodrop", 32'(drop_cnt[3] - d), 32'd1);

        // fixed channel 2, switch to round-robin mid-packet
        Mode = 2'd0;
        Fixed_Ch = 2'd2;
        b = oq.size();
        put_pkt(0, 4, 8'hA0);
        repeat (5) step();
        check("fix_ignore_ch0", 32'(oq.size() - b), 32'd0);
        put_pkt(2, 6, 8'hB0);
        wait_valid("fix_start");
        step();
        check("fix_busy", 32'(Busy), 32'd1);
        Mode = 2'd1;
        repeat (16) step();
        check("fix_count", 32'(oq.size() - b), 32'd10);
        expect_pkt("fix_ch2", b, 6, 8'hB0);
        expect_pkt("fix_then_ch0", b + 6, 4, 8'hA0);

        // reset in the middle of a send
        b = oq.size();
        put_pkt(1, 8, 8'hC0);
        wait_valid("rst_start");
        step();
        step();
        #2;
        Rstn = 1'b0;
        #1;
        check("arst_valid", 32'(Eth_Byte_Valid), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_byte", 32'(Eth_Byte), 32'd0);
        step();
        step();
        Rstn = 1'b1;
        n = oq.size();
        repeat (10) step();
        check("arst_quiet", 32'(oq.size()), 32'(n));
        eops = 0;
        for (int i = b; i < n; i++) if (oq[i][ETH_EOP_BIT]) eops++;
        check("arst_partial", 32'(n - b > 0), 32'd1);
        check("arst_no_eop", 32'(eops), 32'd0);
        put_pkt(3, 3, 8'hE0);
        repeat (10) step();
        check("arst_new_count", 32'(oq.size() - n), 32'd3);
        expect_pkt("arst_new", n, 3, 8'hE0);

        check("idle_zero", 32'(zero_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
